// File: rtl/safe_access_ctrl.sv
// safe_access_ctrl: button sync/strobe, failed-attempt lockout with escalation, and password-change sequencing
module safe_access_ctrl #(
  parameter int BTN_W     = 4,
  parameter int MAX_ERR   = 3,
  parameter int LOCK_BASE = 1000,
  parameter int MAX_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_W-1:0]   btn_raw,
  input  logic               ms_req,
  input  logic               attempt_ok,
  input  logic               attempt_fail,
  input  logic               unlocked_in,
  output logic [BTN_W-1:0]   btn_out,
  output logic               btn_valid,
  output logic               ms_grant,
  output logic               prog_done,
  output logic               locked_out,
  output logic [MAX_ERR-1:0] err_leds,
  output logic [1:0]         lock_level
);
  localparam int TW = $clog2((LOCK_BASE << MAX_SHIFT) + 1);
  localparam int EW = $clog2(MAX_ERR + 1);
  typedef enum logic [3:0] {
    ARMED   = 4'b0001,
    LOCKOUT = 4'b0010,
    OPEN    = 4'b0100,
    PROGRAM = 4'b1000
  } state_t;
  state_t state_q, state_d;
  logic [BTN_W-1:0] s1_q, s2_q, prev_q, btn_out_q, btn_out_d;
  logic btn_valid_q, btn_valid_d, ms_prev_q, ms_grant_q, ms_grant_d;
  logic prog_done_q, prog_done_d, locked_out_q, press;
  logic [EW-1:0] err_q, err_d;
  logic [1:0] lvl_q, lvl_d, cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  assign press      = (|s2_q) && !(|prev_q);
  assign btn_out    = btn_out_q;
  assign btn_valid  = btn_valid_q;
  assign ms_grant   = ms_grant_q;
  assign prog_done  = prog_done_q;
  assign locked_out = locked_out_q;
  assign lock_level = lvl_q;
  for (genvar g = 0; g < MAX_ERR; g++) begin : g_leds
    assign err_leds[g] = err_q > EW'(g);
  end
  // next-state, counters and output pulses; a press only strobes on a 0 -> non-zero transition
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    lvl_d       = lvl_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    ms_grant_d  = 1'b0;
    prog_done_d = 1'b0;
    btn_valid_d = press && (state_q != LOCKOUT);
    btn_out_d   = btn_valid_d ? s2_q : btn_out_q;
    case (state_q)
      ARMED: begin
        if (attempt_ok) begin
          state_d = OPEN;
          err_d   = '0;
          lvl_d   = '0;
        end else if (attempt_fail) begin
          if (err_q + 1'b1 == EW'(MAX_ERR)) begin
            state_d = LOCKOUT;
            timer_d = TW'(LOCK_BASE) << lvl_q;
            err_d   = EW'(MAX_ERR);
          end else begin
            err_d = err_q + 1'b1;
          end
        end
      end
      LOCKOUT: begin
        timer_d = timer_q - 1'b1;
        if (timer_q == TW'(1)) begin
          state_d = ARMED;
          err_d   = '0;
          lvl_d   = (lvl_q == 2'(MAX_SHIFT)) ? lvl_q : lvl_q + 2'd1;
        end
      end
      OPEN: begin
        if (!unlocked_in) begin
          state_d = ARMED;
        end else if (ms_req && !ms_prev_q) begin
          state_d    = PROGRAM;
          ms_grant_d = 1'b1;
          cnt_d      = '0;
        end
      end
      PROGRAM: begin
        if (!ms_req) begin
          state_d = ARMED;
        end else if (btn_valid_q) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            prog_done_d = 1'b1;
            state_d     = ARMED;
            err_d       = '0;
          end
        end
      end
      default: state_d = ARMED;
    endcase
  end
  // state, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARMED;
      s1_q         <= '0;
      s2_q         <= '0;
      prev_q       <= '0;
      btn_out_q    <= '0;
      btn_valid_q  <= 1'b0;
      ms_prev_q    <= 1'b0;
      ms_grant_q   <= 1'b0;
      prog_done_q  <= 1'b0;
      locked_out_q <= 1'b0;
      err_q        <= '0;
      lvl_q        <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= btn_raw;
      s2_q         <= s1_q;
      prev_q       <= s2_q;
      btn_out_q    <= btn_out_d;
      btn_valid_q  <= btn_valid_d;
      ms_prev_q    <= ms_req;
      ms_grant_q   <= ms_grant_d;
      prog_done_q  <= prog_done_d;
      locked_out_q <= state_d == LOCKOUT;
      err_q        <= err_d;
      lvl_q        <= lvl_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
    end
  end
endmodule

// File: tb/tb_safe_access_ctrl.sv
// tb_safe_access_ctrl: directed scenario tests for safe_access_ctrl
module tb_safe_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btn_raw = '0;
  logic ms_req = 1'b0, attempt_ok = 1'b0, attempt_fail = 1'b0, unlocked_in = 1'b0;
  logic [3:0] btn_out;
  logic btn_valid, ms_grant, prog_done, locked_out;
  logic [2:0] err_leds;
  logic [1:0] lock_level;
  int checks = 0;
  int fails = 0;

  safe_access_ctrl #(.BTN_W(4), .MAX_ERR(3), .LOCK_BASE(8), .MAX_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .ms_req(ms_req), .attempt_ok(attempt_ok),
    .attempt_fail(attempt_fail), .unlocked_in(unlocked_in), .btn_out(btn_out), .btn_valid(btn_valid),
    .ms_grant(ms_grant), .prog_done(prog_done), .locked_out(locked_out), .err_leds(err_leds),
    .lock_level(lock_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fail_pulse();
    attempt_fail = 1'b1;
    tick();
    attempt_fail = 1'b0;
  endtask

  task automatic ok_pulse();
    attempt_ok = 1'b1;
    tick();
    attempt_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (btn_valid !== 1'b0) begin fails++; $display("FAIL reset_btn_valid: got %b want 0", btn_valid); end
    checks++; if (btn_out !== 4'h0) begin fails++; $display("FAIL reset_btn_out: got %h want 0", btn_out); end
    checks++; if (locked_out !== 1'b0) begin fails++; $display("FAIL reset_locked_out: got %b want 0", locked_out); end
    checks++; if (err_leds !== 3'b000) begin fails++; $display("FAIL reset_err_leds: got %b want 000", err_leds); end
    checks++; if (lock_level !== 2'd0) begin fails++; $display("FAIL reset_lock_level: got %0d want 0", lock_level); end
    checks++; if ({ms_grant, prog_done} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {ms_grant, prog_done}); end
    checks++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL reset_state: got %b want 0001", dut.state_q); end
    rst = 1'b0;
  endtask

  task automatic test_press();
    int n;
    int first;
    n = 0;
    first = -1;
    btn_raw = 4'b0111;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (btn_valid) begin
        n++;
        if (first < 0) first = i;
      end
    end
    checks++; if (n !== 1) begin fails++; $display("FAIL hold_strobes: got %0d want 1", n); end
    checks++; if (first !== 3) begin fails++; $display("FAIL press_latency: got %0d want 3", first); end
    checks++; if (btn_out !== 4'b0111) begin fails++; $display("FAIL press_value1: got %b want 0111", btn_out); end
    btn_raw = 4'b0000;
    repeat (4) tick();
    btn_raw = 4'b1101;
    n = 0;
    repeat (10) begin tick(); n += int'(btn_valid); end
    checks++; if (n !== 1) begin fails++; $display("FAIL second_press_strobes: got %0d want 1", n); end
    checks++; if (btn_out !== 4'b1101) begin fails++; $display("FAIL press_value2: got %b want 1101", btn_out); end
    btn_raw = 4'b0000;
    repeat (4) tick();
    btn_raw = 4'b0001;
    repeat (6) tick();
    btn_raw = 4'b0011;
    n = 0;
    repeat (8) begin tick(); n += int'(btn_valid); end
    checks++; if (n !== 0) begin fails++; $display("FAIL change_no_release: got %0d strobes want 0", n); end
    checks++; if (btn_out !== 4'b0001) begin fails++; $display("FAIL change_value_held: got %b want 0001", btn_out); end
    btn_raw = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic run_lockout(input int dur, input logic [1:0] lvl, input bit press);
    int n;
    int v;
    fail_pulse();
    checks++; if (err_leds !== 3'b001) begin fails++; $display("FAIL err_leds_1: got %b want 001", err_leds); end
    fail_pulse();
    checks++; if (err_leds !== 3'b011) begin fails++; $display("FAIL err_leds_2: got %b want 011", err_leds); end
    fail_pulse();
    checks++; if (err_leds !== 3'b111) begin fails++; $display("FAIL err_leds_3: got %b want 111", err_leds); end
    checks++; if (locked_out !== 1'b1) begin fails++; $display("FAIL lockout_entry: got %b want 1", locked_out); end
    if (press) btn_raw = 4'b0010;
    n = 0;
    v = 0;
    while (locked_out && n < 200) begin
      n++;
      if (n == 5) btn_raw = 4'b0000;
      v += int'(btn_valid);
      tick();
    end
    repeat (3) begin v += int'(btn_valid); tick(); end
    checks++; if (n !== dur) begin fails++; $display("FAIL lockout_duration: got %0d want %0d", n, dur); end
    checks++; if (v !== 0) begin fails++; $display("FAIL lockout_strobes: got %0d want 0", v); end
    checks++; if (err_leds !== 3'b000) begin fails++; $display("FAIL lockout_exit_err: got %b want 000", err_leds); end
    checks++; if (lock_level !== lvl) begin fails++; $display("FAIL lockout_level: got %0d want %0d", lock_level, lvl); end
  endtask

  task automatic test_lockout();
    run_lockout(8, 2'd1, 1'b1);
    checks++; if (btn_out !== 4'b0001) begin fails++; $display("FAIL lockout_btn_out_hold: got %b want 0001", btn_out); end
    checks++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL lockout_exit_state: got %b want 0001", dut.state_q); end
  endtask

  task automatic test_escalation();
    run_lockout(16, 2'd2, 1'b0);
    run_lockout(32, 2'd3, 1'b0);
    run_lockout(64, 2'd3, 1'b0);
    run_lockout(64, 2'd3, 1'b0);
    unlocked_in = 1'b1;
    ok_pulse();
    checks++; if (lock_level !== 2'd0) begin fails++; $display("FAIL ok_clears_level: got %0d want 0", lock_level); end
    checks++; if (dut.state_q !== 4'b0100) begin fails++; $display("FAIL ok_to_open: got %b want 0100", dut.state_q); end
  endtask

  task automatic test_simultaneous();
    unlocked_in = 1'b0;
    tick();
    checks++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL open_relock: got %b want 0001", dut.state_q); end
    unlocked_in = 1'b1;
    fail_pulse();
    fail_pulse();
    checks++; if (err_leds !== 3'b011) begin fails++; $display("FAIL simul_pre_err: got %b want 011", err_leds); end
    attempt_ok = 1'b1;
    attempt_fail = 1'b1;
    tick();
    attempt_ok = 1'b0;
    attempt_fail = 1'b0;
    checks++; if (dut.state_q !== 4'b0100) begin fails++; $display("FAIL simul_state: got %b want 0100", dut.state_q); end
    checks++; if (err_leds !== 3'b000) begin fails++; $display("FAIL simul_err: got %b want 000", err_leds); end
    checks++; if (locked_out !== 1'b0) begin fails++; $display("FAIL simul_locked: got %b want 0", locked_out); end
    tick();
    checks++; if (locked_out !== 1'b0) begin fails++; $display("FAIL simul_locked_late: got %b want 0", locked_out); end
  endtask

  task automatic test_program();
    logic [3:0] vals [3];
    vals[0] = 4'h1;
    vals[1] = 4'h2;
    vals[2] = 4'h4;
    ms_req = 1'b1;
    tick();
    checks++; if (ms_grant !== 1'b1) begin fails++; $display("FAIL grant_pulse: got %b want 1", ms_grant); end
    checks++; if (dut.state_q !== 4'b1000) begin fails++; $display("FAIL program_state: got %b want 1000", dut.state_q); end
    tick();
    checks++; if (ms_grant !== 1'b0) begin fails++; $display("FAIL grant_one_cycle: got %b want 0", ms_grant); end
    for (int k = 0; k < 3; k++) begin
      btn_raw = vals[k];
      repeat (3) tick();
      checks++; if (btn_valid !== 1'b1) begin fails++; $display("FAIL prog_press_%0d: got %b want 1", k, btn_valid); end
      btn_raw = 4'h0;
      tick();
      checks++; if (prog_done !== (k == 2)) begin fails++; $display("FAIL prog_done_%0d: got %b want %b", k, prog_done, k == 2); end
      if (k == 2) begin
        checks++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL prog_exit_state: got %b want 0001", dut.state_q); end
        tick();
        checks++; if (prog_done !== 1'b0) begin fails++; $display("FAIL prog_done_width: got %b want 0", prog_done); end
      end else begin
        repeat (3) tick();
      end
    end
    ms_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_ms_rules();
    int n;
    ms_req = 1'b1;
    tick();
    checks++; if (ms_grant !== 1'b0) begin fails++; $display("FAIL armed_no_grant: got %b want 0", ms_grant); end
    tick();
    checks++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL armed_ignores_ms: got %b want 0001", dut.state_q); end
    ms_req = 1'b0;
    tick();
    unlocked_in = 1'b1;
    ok_pulse();
    unlocked_in = 1'b0;
    ms_req = 1'b1;
    tick();
    checks++; if (ms_grant !== 1'b0) begin fails++; $display("FAIL unlock_priority_grant: got %b want 0", ms_grant); end
    checks++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL unlock_priority_state: got %b want 0001", dut.state_q); end
    unlocked_in = 1'b1;
    ok_pulse();
    n = 0;
    repeat (3) begin tick(); n += int'(ms_grant); end
    checks++; if (n !== 0) begin fails++; $display("FAIL level_no_grant: got %0d want 0", n); end
    checks++; if (dut.state_q !== 4'b0100) begin fails++; $display("FAIL level_stays_open: got %b want 0100", dut.state_q); end
    ms_req = 1'b0;
    tick();
    ms_req = 1'b1;
    tick();
    checks++; if (ms_grant !== 1'b1) begin fails++; $display("FAIL rise_grant: got %b want 1", ms_grant); end
    ms_req = 1'b0;
    tick();
    checks++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL abort_state: got %b want 0001", dut.state_q); end
    tick();
    checks++; if (prog_done !== 1'b0) begin fails++; $display("FAIL abort_no_done: got %b want 0", prog_done); end
  endtask

  task automatic test_reset_mid_lockout();
    int n;
    run_lockout(8, 2'd1, 1'b0);
    fail_pulse();
    fail_pulse();
    fail_pulse();
    btn_raw = 4'b1000;
    tick();
    tick();
    checks++; if (locked_out !== 1'b1) begin fails++; $display("FAIL mid_lockout_high: got %b want 1", locked_out); end
    rst = 1'b1;
    btn_raw = 4'b0000;
    tick();
    rst = 1'b0;
    checks++; if (locked_out !== 1'b0) begin fails++; $display("FAIL rst_locked_out: got %b want 0", locked_out); end
    checks++; if (err_leds !== 3'b000) begin fails++; $display("FAIL rst_err_leds: got %b want 000", err_leds); end
    checks++; if (lock_level !== 2'd0) begin fails++; $display("FAIL rst_lock_level: got %0d want 0", lock_level); end
    checks++; if (dut.state_q !== 4'b0001) begin fails++; $display("FAIL rst_state: got %b want 0001", dut.state_q); end
    checks++; if (btn_out !== 4'h0) begin fails++; $display("FAIL rst_btn_out: got %h want 0", btn_out); end
    n = int'(btn_valid);
    repeat (6) begin tick(); n += int'(btn_valid); end
    checks++; if (n !== 0) begin fails++; $display("FAIL rst_spurious_strobe: got %0d want 0", n); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_lockout();
    test_escalation();
    test_simultaneous();
    test_program();
    test_ms_rules();
    test_reset_mid_lockout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
